aip_conv_engine: RTL and testbench

Parametrised successor to the fixed-size AIP convolution core. It holds two input sequences, X and Y, in internal memories loaded over the standard AIP config/data bus. It computes their full 1-D convolution or correlation using one multiply-accumulate (MAC) per cycle, and can right-shift and saturate each result. Results land in an output memory. Completion or configuration error is reported through the STATUS register and an active-low `int_req`.

---
 rtl/aip_conv_engine.sv | 216 +++++++++++++++++++++
 tb/tb_aip_conv_engine.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/aip_conv_engine.sv
// AIP convolution/correlation engine: X/Y sample memories, one unsigned MAC per
// cycle, shifted and saturated results stored to an OUT memory.
module aip_conv_engine #(
  parameter int                   DATAWIDTH = 32,
  parameter int                   AW        = 5,
  parameter logic [DATAWIDTH-1:0] IP_ID     = 32'h4004_8009
) (
  input  logic                 clk,
  input  logic                 rst_a,
  input  logic                 en_s,
  input  logic [DATAWIDTH-1:0] data_in,
  output logic [DATAWIDTH-1:0] data_out,
  input  logic                 write,
  input  logic                 read,
  input  logic                 start,
  input  logic [4:0]           conf_dbus,
  output logic                 int_req
);
  localparam int SW     = AW + 1;
  localparam int DEPTH  = 1 << AW;
  localparam int ODEPTH = 1 << (AW + 1);
  localparam int ACCW   = 2 * DATAWIDTH + AW + 1;
  localparam int CFGW   = 2 * SW + 6;

  localparam logic [4:0] SEL_XMEM = 5'd0,  SEL_XPTR = 5'd1,  SEL_YMEM = 5'd2,
                         SEL_YPTR = 5'd3,  SEL_OMEM = 5'd4,  SEL_OPTR = 5'd5,
                         SEL_CFG  = 5'd6,  SEL_STAT = 5'd30, SEL_ID   = 5'd31;

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_DRAIN, S_WRITE, S_DONE} state_t;
  state_t state_q, state_d;

  logic [DATAWIDTH-1:0] x_mem   [DEPTH];
  logic [DATAWIDTH-1:0] y_mem   [DEPTH];
  logic [DATAWIDTH-1:0] out_mem [ODEPTH];

  logic [AW-1:0]        x_ptr_q, y_ptr_q;
  logic [AW:0]          o_ptr_q;
  logic [CFGW-1:0]      cfg_q;
  logic [7:0]           mask_q;
  logic                 done_q, err_q;
  logic [SW:0]          n_q;
  logic [SW-1:0]        k_q;
  logic [DATAWIDTH-1:0] xop_q, yop_q;
  logic [ACCW-1:0]      acc_q;
  logic [DATAWIDTH-1:0] data_out_q;

  logic [SW-1:0] size_x, size_y;
  logic          mode;
  logic [4:0]    shift;
  assign size_x = cfg_q[SW-1:0];
  assign size_y = cfg_q[2*SW-1:SW];
  assign mode   = cfg_q[2*SW];
  assign shift  = cfg_q[2*SW+5:2*SW+1];

  logic busy, cfg_ok, start_ok, go;
  assign busy     = (state_q != S_IDLE);
  assign cfg_ok   = (size_x != '0) && (size_y != '0) &&
                    ({1'b0, size_x} <= (SW+1)'(DEPTH)) &&
                    ({1'b0, size_y} <= (SW+1)'(DEPTH));
  assign start_ok = en_s && start && !busy;
  assign go       = start_ok && cfg_ok;

  logic [SW-1:0] last_k;
  logic [SW:0]   last_n;
  assign last_k = size_x - SW'(1);
  assign last_n = {1'b0, size_x} + {1'b0, size_y} - (SW+1)'(2);

  // Bus strobes; config-side writes are locked out while a run is in progress.
  logic wr_en, rd_en;
  assign wr_en = en_s && write;
  assign rd_en = en_s && read;

  logic wr_xmem, wr_xptr, wr_ymem, wr_yptr, wr_optr, wr_cfg, wr_stat;
  logic rd_xmem, rd_ymem, rd_omem;
  assign wr_xmem = wr_en && !busy && (conf_dbus == SEL_XMEM);
  assign wr_xptr = wr_en && !busy && (conf_dbus == SEL_XPTR);
  assign wr_ymem = wr_en && !busy && (conf_dbus == SEL_YMEM);
  assign wr_yptr = wr_en && !busy && (conf_dbus == SEL_YPTR);
  assign wr_optr = wr_en && !busy && (conf_dbus == SEL_OPTR);
  assign wr_cfg  = wr_en && !busy && (conf_dbus == SEL_CFG);
  assign wr_stat = wr_en && (conf_dbus == SEL_STAT);
  assign rd_xmem = rd_en && (conf_dbus == SEL_XMEM);
  assign rd_ymem = rd_en && (conf_dbus == SEL_YMEM);
  assign rd_omem = rd_en && (conf_dbus == SEL_OMEM);

  // j = n - k; correlation walks Y backwards.
  logic signed [SW+1:0] j;
  logic                 j_ok;
  logic [AW-1:0]        y_addr;
  assign j      = $signed({1'b0, n_q}) - $signed({2'b00, k_q});
  assign j_ok   = !j[SW+1] && (j[SW:0] < {1'b0, size_y});
  assign y_addr = mode ? AW'({1'b0, size_y} - (SW+1)'(1) - j[SW:0]) : j[AW-1:0];

  logic [2*DATAWIDTH-1:0] prod;
  logic [ACCW-1:0]        shifted;
  logic [DATAWIDTH-1:0]   res;
  assign prod    = {{DATAWIDTH{1'b0}}, xop_q} * {{DATAWIDTH{1'b0}}, yop_q};
  assign shifted = acc_q >> shift;
  assign res     = (|shifted[ACCW-1:DATAWIDTH]) ? '1 : shifted[DATAWIDTH-1:0];

  logic [DATAWIDTH-1:0] status, rdata;
  always_comb begin
    status        = '0;
    status[0]     = done_q;
    status[1]     = busy;
    status[2]     = err_q;
    status[23:16] = mask_q;
  end

  always_comb begin
    rdata = '0;
    case (conf_dbus)
      SEL_XMEM: rdata = x_mem[x_ptr_q];
      SEL_XPTR: rdata = DATAWIDTH'(x_ptr_q);
      SEL_YMEM: rdata = y_mem[y_ptr_q];
      SEL_YPTR: rdata = DATAWIDTH'(y_ptr_q);
      SEL_OMEM: rdata = out_mem[o_ptr_q];
      SEL_OPTR: rdata = DATAWIDTH'(o_ptr_q);
      SEL_CFG:  rdata = DATAWIDTH'(cfg_q);
      SEL_STAT: rdata = status;
      SEL_ID:   rdata = IP_ID;
      default:  rdata = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (go) state_d = S_MAC;
      S_MAC:   if (k_q == last_k) state_d = S_DRAIN;
      S_DRAIN: state_d = S_WRITE;
      S_WRITE: state_d = (n_q == last_n) ? S_DONE : S_MAC;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_a) begin
      state_q    <= S_IDLE;
      x_ptr_q    <= '0;
      y_ptr_q    <= '0;
      o_ptr_q    <= '0;
      cfg_q      <= '0;
      mask_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      n_q        <= '0;
      k_q        <= '0;
      xop_q      <= '0;
      yop_q      <= '0;
      acc_q      <= '0;
      data_out_q <= '0;
    end else if (en_s) begin
      state_q <= state_d;

      if (wr_xptr)                 x_ptr_q <= data_in[AW-1:0];
      else if (wr_xmem || rd_xmem) x_ptr_q <= x_ptr_q + AW'(1);
      if (wr_yptr)                 y_ptr_q <= data_in[AW-1:0];
      else if (wr_ymem || rd_ymem) y_ptr_q <= y_ptr_q + AW'(1);
      if (wr_optr)                 o_ptr_q <= data_in[AW:0];
      else if (rd_omem)            o_ptr_q <= o_ptr_q + (AW+1)'(1);

      if (wr_cfg)  cfg_q  <= data_in[CFGW-1:0];
      if (read)    data_out_q <= rdata;
      if (wr_stat) mask_q <= data_in[23:16];

      // Clears first so a same-cycle set takes priority.
      if (wr_stat && data_in[0]) done_q <= 1'b0;
      if (wr_stat && data_in[2]) err_q  <= 1'b0;
      if (go) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end
      if (start_ok && !cfg_ok) begin
        done_q <= 1'b1;
        err_q  <= 1'b1;
      end
      if (state_q == S_DONE) done_q <= 1'b1;

      if (go) begin
        n_q <= '0;
        k_q <= '0;
      end else if (state_q == S_MAC) begin
        k_q <= (k_q == last_k) ? '0 : k_q + SW'(1);
      end else if (state_q == S_WRITE) begin
        n_q <= n_q + (SW+1)'(1);
        k_q <= '0;
      end

      // Out-of-range terms load zero operands, so the accumulate never needs gating.
      if (state_q == S_MAC) begin
        xop_q <= x_mem[k_q[AW-1:0]];
        yop_q <= j_ok ? y_mem[y_addr] : '0;
      end else begin
        xop_q <= '0;
        yop_q <= '0;
      end

      if (go || state_q == S_WRITE) acc_q <= '0;
      else                          acc_q <= acc_q + ACCW'(prod);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_a) begin
      if (wr_xmem) x_mem[x_ptr_q] <= data_in;
      if (wr_ymem) y_mem[y_ptr_q] <= data_in;
      if (en_s && state_q == S_WRITE) out_mem[n_q[AW:0]] <= res;
    end
  end

  assign data_out = data_out_q;
  assign int_req  = ~((done_q & mask_q[0]) | (err_q & mask_q[2]));

endmodule

// File: tb/tb_aip_conv_engine.sv
// Directed bench for aip_conv_engine: hand-computed results, latencies and flags.
module tb_aip_conv_engine;
  logic        clk = 1'b0;
  logic        rst_a, en_s, write, read, start, int_req;
  logic [31:0] data_in, data_out;
  logic [4:0]  conf_dbus;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  aip_conv_engine #(.DATAWIDTH(32), .AW(5), .IP_ID(32'h4004_8009)) dut (
    .clk(clk), .rst_a(rst_a), .en_s(en_s), .data_in(data_in), .data_out(data_out),
    .write(write), .read(read), .start(start), .conf_dbus(conf_dbus), .int_req(int_req)
  );

  logic [31:0] exp_basic [14] = '{1, 3, 6, 10, 15, 15, 15, 15, 15, 15, 14, 12, 9, 5};
  logic [31:0] exp_mode  [6]  = '{3, 10, 8, 4, 11, 6};
  logic [31:0] exp_shift [3]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
  int          shifts    [3]  = '{0, 2, 3};

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] sel, input logic [31:0] d);
    conf_dbus = sel; data_in = d; write = 1'b1;
    tick(1);
    write = 1'b0;
  endtask

  task automatic rd(input logic [4:0] sel, output logic [31:0] v);
    conf_dbus = sel; read = 1'b1;
    tick(1);
    read = 1'b0;
    v = data_out;
  endtask

  function automatic logic [31:0] cfgw(input int sx, input int sy, input int m, input int sh);
    return 32'(sx) | (32'(sy) << 6) | (32'(m) << 12) | (32'(sh) << 13);
  endfunction

  // Pulse start and count edges until int_req falls (bounded).
  task automatic run(output int cyc);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    cyc = 0;
    while (int_req && cyc < 2000) begin
      tick(1);
      cyc++;
    end
  endtask

  task automatic load_basic();
    wr(5'd1, 0);
    for (int i = 1; i <= 5; i++) wr(5'd0, 32'(i));
    wr(5'd3, 0);
    for (int i = 0; i < 10; i++) wr(5'd2, 1);
    wr(5'd6, cfgw(5, 10, 0, 0));
    wr(5'd30, 32'h0001_0005);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst_a = 1'b1;
    tick(2);
    rst_a = 1'b0;
    checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL reset_int_req got %b expected 1", int_req); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data_out got %h expected 0", data_out); end
    rd(5'd30, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_status got %h expected 0", v); end
    rd(5'd31, v);
    checks++; if (v !== 32'h4004_8009) begin errors++; $display("FAIL ip_id got %h expected 40048009", v); end
  endtask

  task automatic test_basic();
    int c;
    logic [31:0] v;
    load_basic();
    run(c);
    checks++; if (c != 99) begin errors++; $display("FAIL basic_latency got %0d expected 99", c); end
    wr(5'd5, 0);
    for (int i = 0; i < 14; i++) begin
      rd(5'd4, v);
      checks++; if (v !== exp_basic[i]) begin errors++; $display("FAIL basic_out[%0d] got %h expected %h", i, v, exp_basic[i]); end
    end
    rd(5'd30, v);
    checks++; if (v !== 32'h0001_0001) begin errors++; $display("FAIL basic_status got %h expected 00010001", v); end
  endtask

  task automatic test_mode();
    int c;
    logic [31:0] v;
    for (int m = 0; m < 2; m++) begin
      wr(5'd1, 0); wr(5'd0, 1); wr(5'd0, 2);
      wr(5'd3, 0); wr(5'd2, 3); wr(5'd2, 4);
      wr(5'd6, cfgw(2, 2, m, 0));
      run(c);
      checks++; if (c != 13) begin errors++; $display("FAIL mode%0d_latency got %0d expected 13", m, c); end
      wr(5'd5, 0);
      for (int i = 0; i < 3; i++) begin
        rd(5'd4, v);
        checks++; if (v !== exp_mode[m*3+i]) begin errors++; $display("FAIL mode%0d_out[%0d] got %h expected %h", m, i, v, exp_mode[m*3+i]); end
      end
    end
  endtask

  task automatic test_shift_sat();
    int c;
    logic [31:0] v;
    wr(5'd1, 0); wr(5'd0, 32'hFFFF_FFFF);
    wr(5'd3, 0); wr(5'd2, 4);
    for (int s = 0; s < 3; s++) begin
      wr(5'd6, cfgw(1, 1, 0, shifts[s]));
      run(c);
      checks++; if (c != 4) begin errors++; $display("FAIL shift%0d_latency got %0d expected 4", shifts[s], c); end
      wr(5'd5, 0);
      rd(5'd4, v);
      checks++; if (v !== exp_shift[s]) begin errors++; $display("FAIL shift%0d_out got %h expected %h", shifts[s], v, exp_shift[s]); end
    end
  endtask

  task automatic test_invalid();
    logic [31:0] v;
    wr(5'd30, 32'h0004_0005);
    wr(5'd6, cfgw(0, 1, 0, 0));
    start = 1'b1;
    tick(1);
    start = 1'b0;
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL invalid_int_req got %b expected 0", int_req); end
    rd(5'd30, v);
    checks++; if (v !== 32'h0004_0005) begin errors++; $display("FAIL invalid_status got %h expected 00040005", v); end
    wr(5'd5, 0);
    rd(5'd4, v);
    checks++; if (v !== 32'h7FFF_FFFF) begin errors++; $display("FAIL invalid_out_kept got %h expected 7fffffff", v); end
    wr(5'd30, 32'h0004_0004);
    checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL w1c_int_req got %b expected 1", int_req); end
    rd(5'd30, v);
    checks++; if (v !== 32'h0004_0001) begin errors++; $display("FAIL w1c_status got %h expected 00040001", v); end
  endtask

  task automatic test_reset_mid();
    int c;
    logic [31:0] v;
    load_basic();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(10);
    rst_a = 1'b1;
    tick(1);
    rst_a = 1'b0;
    checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL midrst_int_req got %b expected 1", int_req); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL midrst_data_out got %h expected 0", data_out); end
    rd(5'd30, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL midrst_status got %h expected 0", v); end
    wr(5'd6, cfgw(5, 10, 0, 0));
    wr(5'd30, 32'h0001_0000);
    run(c);
    checks++; if (c != 99) begin errors++; $display("FAIL midrst_latency got %0d expected 99", c); end
    wr(5'd5, 0);
    for (int i = 0; i < 14; i++) begin
      rd(5'd4, v);
      checks++; if (v !== exp_basic[i]) begin errors++; $display("FAIL midrst_out[%0d] got %h expected %h", i, v, exp_basic[i]); end
    end
  endtask

  task automatic test_busy_enable();
    int cnt;
    logic [31:0] v;
    load_basic();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    wr(5'd1, 0);
    wr(5'd0, 100);
    rd(5'd30, v);
    cnt = 6;
    checks++; if (v !== 32'h0001_0002) begin errors++; $display("FAIL busy_status got %h expected 00010002", v); end
    en_s = 1'b0;
    tick(20);
    en_s = 1'b1;
    cnt += 20;
    while (int_req && cnt < 2000) begin
      tick(1);
      cnt++;
    end
    checks++; if (cnt != 119) begin errors++; $display("FAIL enable_latency got %0d expected 119", cnt); end
    wr(5'd5, 0);
    for (int i = 0; i < 14; i++) begin
      rd(5'd4, v);
      checks++; if (v !== exp_basic[i]) begin errors++; $display("FAIL busy_out[%0d] got %h expected %h", i, v, exp_basic[i]); end
    end
    wr(5'd1, 0);
    rd(5'd0, v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL busy_xmem0 got %h expected 1", v); end
  endtask

  initial begin
    rst_a = 1'b1; en_s = 1'b1; write = 1'b0; read = 1'b0; start = 1'b0;
    data_in = '0; conf_dbus = '0;
    test_reset();
    test_basic();
    test_mode();
    test_shift_sat();
    test_invalid();
    test_reset_mid();
    test_busy_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
